// File: rtl/sp3_multi_rx_capture_if.sv
// Uplink frame inputs and word-serial read port of sp3_multi_rx_capture.
// master drives frames and rd_next; slave is the capture block.
interface sp3_multi_rx_capture_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 234
);
  logic [N_CH-1:0]        ch_en;
  logic [N_CH-1:0]        uplinkrdy;
  logic [N_CH-1:0]        uplinkFEC;
  logic [N_CH-1:0]        uplink_valid;
  logic [N_CH*DATA_W-1:0] uplinkUserData;
  logic                   rd_next;
  logic                   rd_valid;
  logic [31:0]            rd_data;
  logic                   rd_last;

  modport master (
    output ch_en, uplinkrdy, uplinkFEC, uplink_valid, uplinkUserData, rd_next,
    input  rd_valid, rd_data, rd_last
  );

  modport slave (
    input  ch_en, uplinkrdy, uplinkFEC, uplink_valid, uplinkUserData, rd_next,
    output rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/sp3_multi_rx_capture.sv
// N-channel uplink capture: per-channel slots, round-robin into a frame FIFO, 32-bit word readout.
// Optional SP3_CAPTURE_TIMESTAMP_EN adds a cycle timestamp word after the header. DEPTH >= 2.
module sp3_multi_rx_capture #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 234,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst,
  sp3_multi_rx_capture_if.slave  bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic [N_CH*CNT_W-1:0]  fec_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);
  localparam int NW = (DATA_W + 31) / 32;
`ifdef SP3_CAPTURE_TIMESTAMP_EN
  localparam int   HW      = 2;
  localparam logic TS_FLAG = 1'b1;
`else
  localparam int   HW      = 1;
  localparam logic TS_FLAG = 1'b0;
`endif
  localparam int FW = NW + HW;
  localparam int IW = $clog2(FW);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]   slot_vld_q, slot_vld_d, slot_fec_q, slot_fec_d;
  logic [DATA_W-1:0] slot_dat_q [N_CH];
  logic [DATA_W-1:0] slot_dat_d [N_CH];
  logic [CNT_W-1:0]  fec_q [N_CH];
  logic [CNT_W-1:0]  fec_d [N_CH];
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CW-1:0]     rr_q, gnt_idx;
  logic              gnt_vld, acc, gnt_i, pop;
  logic [7:0]        seq_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic [IW-1:0]     idx_q;
  logic [31:0]       hdr_mem [DEPTH];
  logic [DATA_W-1:0] dat_mem [DEPTH];
  logic [NW*32-1:0]  dat_pad;
  logic [31:0]       word;
  int                c, wi;
`ifdef SP3_CAPTURE_TIMESTAMP_EN
  logic [31:0]       ts_q;
  logic [31:0]       slot_ts_q [N_CH];
  logic [31:0]       slot_ts_d [N_CH];
  logic [31:0]       ts_mem [DEPTH];
`endif

  // Round-robin search begins one past the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(rr_q) + k) % N_CH;
      if (!gnt_vld && !fifo_full && slot_vld_q[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(c);
      end
    end
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_fec_d = slot_fec_q;
    slot_dat_d = slot_dat_q;
    fec_d      = fec_q;
    drop_d     = drop_q;
    acc        = 1'b0;
    gnt_i      = 1'b0;
`ifdef SP3_CAPTURE_TIMESTAMP_EN
    slot_ts_d  = slot_ts_q;
`endif
    for (int i = 0; i < N_CH; i++) begin
      acc   = bus.uplink_valid[i] & bus.uplinkrdy[i] & bus.ch_en[i];
      gnt_i = gnt_vld && (gnt_idx == CW'(i));
      if (!bus.ch_en[i]) begin
        slot_vld_d[i] = 1'b0;
      end else if (acc) begin
        // A slot being drained this cycle may take the new frame.
        if (!slot_vld_q[i] || gnt_i) begin
          slot_vld_d[i] = 1'b1;
          slot_fec_d[i] = bus.uplinkFEC[i];
          slot_dat_d[i] = bus.uplinkUserData[i*DATA_W +: DATA_W];
`ifdef SP3_CAPTURE_TIMESTAMP_EN
          slot_ts_d[i]  = ts_q;
`endif
        end else if (drop_d != '1) begin
          drop_d = drop_d + CNT_W'(1);
        end
      end else if (gnt_i) begin
        slot_vld_d[i] = 1'b0;
      end
      if (acc && bus.uplinkFEC[i] && (fec_d[i] != '1)) fec_d[i] = fec_d[i] + CNT_W'(1);
    end
  end

  assign pop   = bus.rd_next & bus.rd_valid & bus.rd_last;
  assign cnt_d = cnt_q + (AW+1)'(gnt_vld) - (AW+1)'(pop);

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      slot_vld_q <= '0;
      slot_fec_q <= '0;
      drop_q     <= '0;
      rr_q       <= CW'(N_CH - 1);  // first search after reset starts at channel 0
      seq_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        slot_dat_q[i] <= '0;
        fec_q[i]      <= '0;
      end
`ifdef SP3_CAPTURE_TIMESTAMP_EN
      ts_q <= '0;
      for (int i = 0; i < N_CH; i++) slot_ts_q[i] <= '0;
`endif
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_fec_q <= slot_fec_d;
      slot_dat_q <= slot_dat_d;
      fec_q      <= fec_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      if (gnt_vld) begin
        rr_q     <= gnt_idx;
        seq_q    <= seq_q + 8'd1;
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (bus.rd_next && bus.rd_valid) idx_q <= bus.rd_last ? '0 : idx_q + IW'(1);
`ifdef SP3_CAPTURE_TIMESTAMP_EN
      ts_q      <= ts_q + 32'd1;
      slot_ts_q <= slot_ts_d;
`endif
    end
  end

  always_ff @(posedge axi_clk) begin
    if (gnt_vld) begin
      hdr_mem[wr_ptr_q] <= {8'hA5, seq_q, 8'(gnt_idx), TS_FLAG, 6'd0, slot_fec_q[gnt_idx]};
      dat_mem[wr_ptr_q] <= slot_dat_q[gnt_idx];
`ifdef SP3_CAPTURE_TIMESTAMP_EN
      ts_mem[wr_ptr_q]  <= slot_ts_q[gnt_idx];
`endif
    end
  end

  always_comb begin
    dat_pad = (NW*32)'(dat_mem[rd_ptr_q]);
    word    = '0;
    wi      = 0;
    if (idx_q == '0) begin
      word = hdr_mem[rd_ptr_q];
`ifdef SP3_CAPTURE_TIMESTAMP_EN
    end else if (idx_q == IW'(1)) begin
      word = ts_mem[rd_ptr_q];
`endif
    end else begin
      wi   = int'(idx_q) - HW;
      word = dat_pad[wi*32 +: 32];
    end
  end

  assign bus.rd_valid = (cnt_q != '0);
  assign bus.rd_last  = bus.rd_valid && (idx_q == IW'(FW - 1));
  assign bus.rd_data  = bus.rd_valid ? word : 32'd0;
  assign fifo_count   = cnt_q;
  assign fifo_full    = (cnt_q == (AW+1)'(DEPTH));
  assign drop_cnt     = drop_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_fec
    assign fec_cnt[g*CNT_W +: CNT_W] = fec_q[g];
  end
endmodule

// File: tb/tb_sp3_multi_rx_capture.sv
// Scoreboard bench for sp3_multi_rx_capture: stimulus pushes expected words, a reader process pops and compares.
module tb_sp3_multi_rx_capture;
  localparam int N_CH   = 4;
  localparam int DATA_W = 234;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int NW     = 8;
`ifdef SP3_CAPTURE_TIMESTAMP_EN
  localparam logic [31:0] TSF = 32'h0000_0080;
`else
  localparam logic [31:0] TSF = 32'h0000_0000;
`endif

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } exp_t;

  logic                  axi_clk = 1'b0;
  logic                  axi_rst;
  logic [4:0]            fifo_count;
  logic                  fifo_full;
  logic [N_CH*CNT_W-1:0] fec_cnt;
  logic [CNT_W-1:0]      drop_cnt;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc;
  int          stb_ts;
  bit          reader_on = 1'b0;

  always #5 axi_clk = ~axi_clk;

  sp3_multi_rx_capture_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus();

  sp3_multi_rx_capture #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .axi_clk    (axi_clk),
    .axi_rst    (axi_rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fec_cnt    (fec_cnt),
    .drop_cnt   (drop_cnt)
  );

  always @(posedge axi_clk) begin
    if (axi_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int lo, input int hi);
    logic [DATA_W-1:0] d;
    d = '0;
    d[31:0]    = 32'(lo);
    d[233:224] = 10'(hi);
    return d;
  endfunction

  function automatic logic [31:0] hdr(input int ch, input int seq, input logic fec);
    return {8'hA5, 8'(seq), 8'(ch), 7'd0, fec} | TSF;
  endfunction

  function automatic logic [CNT_W-1:0] fec_of(input int ch);
    return fec_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic push_frame(input logic [31:0] h, input logic [DATA_W-1:0] d);
    logic [NW*32-1:0] p;
    exp_t e;
    p = (NW*32)'(d);
    e.dat = h; e.last = 1'b0; sbq.push_back(e);
`ifdef SP3_CAPTURE_TIMESTAMP_EN
    e.dat = 32'(stb_ts); e.last = 1'b0; sbq.push_back(e);
`endif
    for (int k = 0; k < NW; k++) begin
      e.dat = p[k*32 +: 32]; e.last = (k == NW - 1); sbq.push_back(e);
    end
  endtask

  // Called at a negedge; holds the strobe for exactly one clock.
  task automatic strobe(input logic [N_CH-1:0] v, input logic [N_CH-1:0] fec,
                        input logic [N_CH*DATA_W-1:0] d);
    bus.uplink_valid   = v;
    bus.uplinkFEC      = fec;
    bus.uplinkUserData = d;
    stb_ts             = cyc;
    @(negedge axi_clk);
    bus.uplink_valid   = '0;
    bus.uplinkFEC      = '0;
  endtask

  task automatic do_reset();
    axi_rst            = 1'b1;
    reader_on          = 1'b0;
    bus.ch_en          = '1;
    bus.uplinkrdy      = '1;
    bus.uplink_valid   = '0;
    bus.uplinkFEC      = '0;
    bus.uplinkUserData = '0;
    repeat (2) @(negedge axi_clk);
    axi_rst = 1'b0;
    @(negedge axi_clk);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    reader_on = 1'b1;
    for (int t = 0; t < 3000 && !done; t++) begin
      if (sbq.size() == 0 && !bus.rd_valid) done = 1'b1;
      else @(negedge axi_clk);
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected words left, rd_valid=%0b", name, sbq.size(), bus.rd_valid);
      sbq.delete();
    end
  endtask

  // Reader/monitor: compares each presented word and advances with rd_next.
  initial begin
    exp_t e;
    bus.rd_next = 1'b0;
    forever begin
      @(negedge axi_clk);
      bus.rd_next = 1'b0;
      if (reader_on && bus.rd_valid) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_word: unexpected word %08h last=%0b, expected none", bus.rd_data, bus.rd_last);
        end else begin
          e = sbq.pop_front();
          chk("rd_word", 64'({bus.rd_last, bus.rd_data}), 64'({e.last, e.dat}));
        end
        bus.rd_next = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH*DATA_W-1:0] flat;

    do_reset();
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_rd_last", 64'(bus.rd_last), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_fifo_full", 64'(fifo_full), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_fec_cnt", 64'(fec_cnt), 64'd0);

    // Single frame on ch2, data=1, FEC=1.
    reader_on = 1'b1;
    flat = '0;
    flat[2*DATA_W +: DATA_W] = mk(1, 0);
    strobe(4'b0100, 4'b0100, flat);
    push_frame(32'hA500_0201 | TSF, mk(1, 0));
    chk("lat_edge1_rd_valid", 64'(bus.rd_valid), 64'd0);
    @(negedge axi_clk);
    chk("lat_edge2_rd_valid", 64'(bus.rd_valid), 64'd1);
    drain("single");
    chk("single_fec2", 64'(fec_of(2)), 64'd1);
    chk("single_fifo_count", 64'(fifo_count), 64'd0);

    // Four simultaneous strobes arrive in channel order.
    do_reset();
    flat = '0;
    for (int i = 0; i < N_CH; i++) flat[i*DATA_W +: DATA_W] = mk(32'h1000_0000 + i, 10'h3FF ^ i);
    strobe(4'b1111, 4'b0101, flat);
    for (int i = 0; i < N_CH; i++) push_frame(hdr(i, i, (i % 2) == 0), mk(32'h1000_0000 + i, 10'h3FF ^ i));
    repeat (3) @(negedge axi_clk);
    chk("rr_fifo_count_e4", 64'(fifo_count), 64'd3);
    @(negedge axi_clk);
    chk("rr_fifo_count_e5", 64'(fifo_count), 64'd4);
    drain("rr");
    chk("rr_fec_0", 64'(fec_of(0)), 64'd1);
    chk("rr_fec_1", 64'(fec_of(1)), 64'd0);

    // Fill: 20 back-to-back frames on ch1 with no reader.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      flat = '0;
      flat[1*DATA_W +: DATA_W] = mk(k, 10'h155);
      strobe(4'b0010, 4'b0010, flat);
      if (k <= 16) push_frame(hdr(1, k, 1'b1), mk(k, 10'h155));
    end
    chk("fill_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("fill_fifo_full", 64'(fifo_full), 64'd1);
    chk("fill_fifo_count", 64'(fifo_count), 64'd16);
    chk("fill_fec1", 64'(fec_of(1)), 64'd20);
    drain("fill");
    chk("fill_drop_after", 64'(drop_cnt), 64'd3);
    chk("fill_full_after", 64'(fifo_full), 64'd0);

    // Not ready on ch3, disabled ch0: nothing captured or counted.
    do_reset();
    reader_on = 1'b1;
    bus.uplinkrdy = 4'b0111;
    flat = '1;
    strobe(4'b1000, 4'b1000, flat);
    bus.ch_en = 4'b1110;
    strobe(4'b0001, 4'b0001, flat);
    repeat (4) @(negedge axi_clk);
    chk("ign_fifo_count", 64'(fifo_count), 64'd0);
    chk("ign_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("ign_fec3", 64'(fec_of(3)), 64'd0);
    chk("ign_fec0", 64'(fec_of(0)), 64'd0);
    chk("ign_drop", 64'(drop_cnt), 64'd0);

    // 300 frames with a reader that keeps pace: seq wraps, nothing dropped.
    do_reset();
    reader_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      flat = '0;
      flat[(i % 4)*DATA_W +: DATA_W] = mk(i * 32'h0001_0003, i);
      strobe(4'(1 << (i % 4)), (i % 2) ? 4'(1 << (i % 4)) : 4'd0, flat);
      push_frame(hdr(i % 4, i % 256, (i % 2) == 1), mk(i * 32'h0001_0003, i));
      repeat (9) @(negedge axi_clk);
    end
    drain("wrap");
    chk("wrap_drop", 64'(drop_cnt), 64'd0);
    chk("wrap_fec1", 64'(fec_of(1)), 64'd75);
    chk("wrap_fec3", 64'(fec_of(3)), 64'd75);
    chk("wrap_fec0", 64'(fec_of(0)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
